predictor_bht_check: RTL and testbench

Parametrised branch prediction and resolution unit for the pipeline's branch stage. It keeps a direct-mapped table of saturating counters indexed by branch address and supplies a taken/not-taken prediction at fetch. At resolve it checks the predicted direction against the selected flag (zero, positive or carry), reports a misprediction with the recovery address, and trains the table. It also keeps resolved-branch and misprediction statistics.

---
 rtl/predictor_bht_check.sv | 128 ++++++++++++
 tb/tb_predictor_bht_check.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/predictor_bht_check.sv
// Branch direction predictor (direct-mapped saturating counters) with resolve check and statistics.
// Latency: lookup is combinational; resolve results and table training are visible one cycle after acceptance. No backpressure: one resolve per cycle.
module predictor_bht_check #(
    parameter int ADDR_W   = 11,
    parameter int INDEX_W  = 4,
    parameter int CNT_W    = 2,
    parameter int CNT_INIT = 1,
    parameter int STAT_W   = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [ADDR_W-1:0] lookup_pc,
    output logic              lookup_taken,
    input  logic              resolve_valid,
    input  logic [ADDR_W-1:0] resolve_pc,
    input  logic [1:0]        branch_type,
    input  logic              branch_taken,
    input  logic [ADDR_W-1:0] jump_addr,
    input  logic              W_zero,
    input  logic              W_positive,
    input  logic              carry,
    output logic              resolve_done,
    output logic              prediction_failed,
    output logic              branch_result,
    output logic [ADDR_W-1:0] failback_addr,
    output logic [STAT_W-1:0] stat_branches,
    output logic [STAT_W-1:0] stat_mispredicts
);

    localparam int DEPTH = 1 << INDEX_W;
    localparam logic [CNT_W-1:0] CNT_RST = CNT_W'(CNT_INIT);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_MIN = '0;
    localparam logic [STAT_W-1:0] STAT_MAX = '1;

    logic [CNT_W-1:0]   cnt_table [DEPTH];

    logic [INDEX_W-1:0] lookup_idx;
    logic [INDEX_W-1:0] resolve_idx;
    logic               accept;
    logic               actual;
    logic               failed;
    logic [ADDR_W-1:0]  recover_addr;
    logic [CNT_W-1:0]   cnt_cur;
    logic [CNT_W-1:0]   cnt_next;
    logic               unused_pc_hi;

    // Upper pc bits intentionally take no part in indexing; branches alias.
    assign lookup_idx   = lookup_pc[INDEX_W-1:0];
    assign resolve_idx  = resolve_pc[INDEX_W-1:0];
    assign unused_pc_hi = ^{lookup_pc[ADDR_W-1:INDEX_W], resolve_pc[ADDR_W-1:INDEX_W]};

    // Reads registered state only, so a same-cycle resolve is not bypassed.
    assign lookup_taken = cnt_table[lookup_idx][CNT_W-1];

    assign accept = resolve_valid && (branch_type != 2'b00);

    always_comb begin
        actual = 1'b0;
        unique case (branch_type)
            2'b01:   actual = W_zero;
            2'b10:   actual = W_positive;
            2'b11:   actual = carry;
            default: actual = 1'b0;
        endcase
    end

    assign failed       = (actual != branch_taken);
    assign recover_addr = branch_taken ? (resolve_pc + ADDR_W'(1)) : jump_addr;

    assign cnt_cur = cnt_table[resolve_idx];

    always_comb begin
        cnt_next = cnt_cur;
        if (actual) begin
            if (cnt_cur != CNT_MAX) begin
                cnt_next = cnt_cur + CNT_W'(1);
            end
        end else begin
            if (cnt_cur != CNT_MIN) begin
                cnt_next = cnt_cur - CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                cnt_table[i] <= CNT_RST;
            end
        end else if (accept) begin
            cnt_table[resolve_idx] <= cnt_next;
        end
    end

    // Pulses clear when idle; direction and recovery address hold.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            resolve_done      <= 1'b0;
            prediction_failed <= 1'b0;
            branch_result     <= 1'b0;
            failback_addr     <= '0;
        end else if (accept) begin
            resolve_done      <= 1'b1;
            prediction_failed <= failed;
            branch_result     <= actual;
            failback_addr     <= recover_addr;
        end else begin
            resolve_done      <= 1'b0;
            prediction_failed <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches    <= '0;
            stat_mispredicts <= '0;
        end else if (accept) begin
            if (stat_branches != STAT_MAX) begin
                stat_branches <= stat_branches + STAT_W'(1);
            end
            if (failed && (stat_mispredicts != STAT_MAX)) begin
                stat_mispredicts <= stat_mispredicts + STAT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_predictor_bht_check.sv
// Randomized and directed bench for predictor_bht_check against a behavioural model; a narrow-stat instance checks saturation.
module tb_predictor_bht_check;

    logic        clk;
    logic        rst_n;
    logic [10:0] lookup_pc;
    logic        lookup_taken, lookup_taken4;
    logic        resolve_valid;
    logic [10:0] resolve_pc;
    logic [1:0]  branch_type;
    logic        branch_taken;
    logic [10:0] jump_addr;
    logic        W_zero, W_positive, carry;
    logic        resolve_done, resolve_done4;
    logic        prediction_failed, prediction_failed4;
    logic        branch_result, branch_result4;
    logic [10:0] failback_addr, failback_addr4;
    logic [15:0] stat_branches, stat_mispredicts;
    logic [3:0]  stat_branches4, stat_mispredicts4;

    int checks = 0;
    int errors = 0;

    int   mcnt [16];
    int   mst_b, mst_m;
    bit   e_done, e_fail, e_res;
    int   e_fb;

    predictor_bht_check dut (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .branch_type(branch_type),
        .branch_taken(branch_taken), .jump_addr(jump_addr), .W_zero(W_zero),
        .W_positive(W_positive), .carry(carry), .resolve_done(resolve_done),
        .prediction_failed(prediction_failed), .branch_result(branch_result),
        .failback_addr(failback_addr), .stat_branches(stat_branches),
        .stat_mispredicts(stat_mispredicts)
    );

    predictor_bht_check #(.STAT_W(4)) dut4 (
        .clk(clk), .rst_n(rst_n), .lookup_pc(lookup_pc), .lookup_taken(lookup_taken4),
        .resolve_valid(resolve_valid), .resolve_pc(resolve_pc), .branch_type(branch_type),
        .branch_taken(branch_taken), .jump_addr(jump_addr), .W_zero(W_zero),
        .W_positive(W_positive), .carry(carry), .resolve_done(resolve_done4),
        .prediction_failed(prediction_failed4), .branch_result(branch_result4),
        .failback_addr(failback_addr4), .stat_branches(stat_branches4),
        .stat_mispredicts(stat_mispredicts4)
    );

    initial clk = 1'b0;
    always #50 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) mcnt[i] = 1;
        mst_b = 0; mst_m = 0;
        e_done = 0; e_fail = 0; e_res = 0; e_fb = 0;
    endtask

    task automatic check_outputs(input string tag);
        check_val({tag, ".done"},   resolve_done,       e_done);
        check_val({tag, ".failed"}, prediction_failed,  e_fail);
        check_val({tag, ".result"}, branch_result,      e_res);
        check_val({tag, ".fb"},     failback_addr,      e_fb);
        check_val({tag, ".stb"},    stat_branches,      sat(mst_b, 65535));
        check_val({tag, ".stm"},    stat_mispredicts,   sat(mst_m, 65535));
        check_val({tag, ".stb4"},   stat_branches4,     sat(mst_b, 15));
        check_val({tag, ".stm4"},   stat_mispredicts4,  sat(mst_m, 15));
        check_val({tag, ".done4"},  resolve_done4,      e_done);
    endtask

    task automatic check_table(input string tag);
        for (int i = 0; i < 16; i++) begin
            lookup_pc = 11'(($urandom_range(0, 127) << 4) | i);
            #1;
            check_val({tag, ".tbl"}, lookup_taken, (mcnt[i] >= 2) ? 1 : 0);
        end
    endtask

    // Called at a falling edge; spans one full clock cycle.
    task automatic step(input string tag, input logic [10:0] lpc, input logic rv,
                        input logic [10:0] rpc, input logic [1:0] bt, input logic bp,
                        input logic [10:0] ja, input logic z, input logic p, input logic c);
        bit acc, act;
        int idx;
        lookup_pc = lpc; resolve_valid = rv; resolve_pc = rpc; branch_type = bt;
        branch_taken = bp; jump_addr = ja; W_zero = z; W_positive = p; carry = c;
        #1;
        check_val({tag, ".lookup"}, lookup_taken, (mcnt[int'(lpc) % 16] >= 2) ? 1 : 0);
        acc = rv && (bt != 2'b00);
        act = (bt == 2'b01) ? z : (bt == 2'b10) ? p : c;
        idx = int'(rpc) % 16;
        @(posedge clk);
        if (acc) begin
            e_done = 1;
            e_fail = (act != bp);
            e_res  = act;
            e_fb   = bp ? (int'(rpc) + 1) % 2048 : int'(ja);
            mcnt[idx] = act ? ((mcnt[idx] < 3) ? mcnt[idx] + 1 : 3)
                            : ((mcnt[idx] > 0) ? mcnt[idx] - 1 : 0);
            mst_b++;
            if (act != bp) mst_m++;
        end else begin
            e_done = 0;
            e_fail = 0;
        end
        @(negedge clk);
        check_outputs(tag);
    endtask

    task automatic idle(input string tag);
        step(tag, 11'h000, 1'b0, 11'h000, 2'b00, 1'b0, 11'h000, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic mid_reset(input string tag);
        rst_n = 1'b0;
        #1;
        model_reset();
        check_outputs(tag);
        check_table(tag);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        check_outputs(tag);
    endtask

    initial begin
        logic [10:0] r_pc, l_pc, ja;
        logic [1:0]  bt;
        logic        rv;
        rst_n = 1'b0;
        lookup_pc = 11'h005; resolve_valid = 0; resolve_pc = 0; branch_type = 0;
        branch_taken = 0; jump_addr = 0; W_zero = 0; W_positive = 0; carry = 0;
        model_reset();
        #1;
        check_val("reset.lookup5", lookup_taken, 1'b0);
        check_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Two mispredicted not-taken guesses on a taken branch.
        step("mp1", 11'h005, 1, 11'h005, 2'b01, 0, 11'h123, 1, 0, 0);
        check_val("mp1.fb_const", failback_addr, 11'h123);
        check_val("mp1.lookup_after", lookup_taken, 1'b1);
        step("mp2", 11'h005, 1, 11'h005, 2'b01, 0, 11'h123, 1, 0, 0);
        idle("mp.idle");
        check_val("mp.stm_const", stat_mispredicts, 16'd2);
        check_val("mp.fb_hold", failback_addr, 11'h123);

        // Saturation at the top, then a single not-taken step.
        for (int i = 0; i < 5; i++)
            step("sat", 11'h003, 1, 11'h003, 2'b01, 1, 11'h055, 1, 0, 0);
        check_val("sat.lookup", lookup_taken, 1'b1);
        step("dec", 11'h003, 1, 11'h003, 2'b11, 1, 11'h055, 0, 0, 0);
        check_val("dec.fb_const", failback_addr, 11'h004);
        idle("dec.idle");
        check_table("dec");

        // Address wrap and index aliasing onto entry 15.
        step("wrap", 11'h00F, 1, 11'h7FF, 2'b10, 1, 11'h200, 0, 1, 0);
        check_val("wrap.fb_const", failback_addr, 11'h000);
        check_val("wrap.failed_const", prediction_failed, 1'b0);
        step("alias", 11'h00F, 0, 11'h000, 2'b00, 0, 11'h000, 0, 0, 0);

        // Ignored requests.
        step("type0", 11'h005, 1, 11'h005, 2'b00, 0, 11'h3AA, 1, 1, 1);
        step("novld", 11'h005, 0, 11'h005, 2'b01, 0, 11'h3AA, 1, 1, 1);
        check_table("ign");

        // Same-cycle lookup and resolve on one index sees the old value.
        step("nobyp1", 11'h00A, 1, 11'h01A, 2'b01, 1, 11'h000, 1, 0, 0);
        step("nobyp2", 11'h02A, 1, 11'h00A, 2'b01, 1, 11'h000, 1, 0, 0);

        // Reset in the cycle after an accepted resolve.
        step("pre_rst", 11'h001, 1, 11'h001, 2'b01, 0, 11'h111, 1, 0, 0);
        mid_reset("midrst");

        // Enough back-to-back resolves to saturate the narrow statistics.
        for (int i = 0; i < 20; i++)
            step("b2b", 11'(i), 1, 11'(i * 7), 2'(1 + (i % 3)), 1'(i % 2), 11'(i * 13),
                 1'(i % 2), 1'((i / 2) % 2), 1'((i / 3) % 2));
        check_val("b2b.stb4_const", stat_branches4, 4'd15);
        check_val("b2b.stb_const", stat_branches, 16'd20);

        // Random traffic on a small set of hot indices.
        for (int n = 0; n < 600; n++) begin
            r_pc = 11'($urandom_range(0, 2047));
            if ($urandom_range(0, 3) != 0) r_pc[3:0] = 4'($urandom_range(0, 3));
            l_pc = ($urandom_range(0, 3) == 0) ? r_pc : 11'($urandom_range(0, 2047));
            ja   = 11'($urandom_range(0, 2047));
            bt   = 2'($urandom_range(0, 3));
            rv   = ($urandom_range(0, 4) != 0);
            step("rnd", l_pc, rv, r_pc, bt, 1'($urandom_range(0, 1)), ja,
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            if ($urandom_range(0, 199) == 0) mid_reset("rnd.rst");
        end
        idle("end");
        check_table("end");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
